// File: rtl/legv8_pkg.sv
// Shared LEGv8 decode constants: register-address width, zero-register index
// and the instruction bit positions of the Rn, Rm and Rt fields.
package legv8_pkg;

    localparam int REG_AW       = 5;
    localparam int NREG         = 1 << REG_AW;
    localparam int ZREG_DEFAULT = 31;

    localparam int RN_LSB = 5;
    localparam int RM_LSB = 16;
    localparam int RT_LSB = 0;

endpackage

// File: rtl/mux2.sv
// Generic two-input multiplexer.
module mux2 #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic             s,
    output logic [WIDTH-1:0] y
);

    assign y = s ? d1 : d0;

endmodule

// File: rtl/regfile_bp.sv
// 32-entry register file with two combinational read ports, a hard-wired zero
// register, optional write-first bypass and a synchronous clear on reset.
module regfile_bp
    import legv8_pkg::*;
#(
    parameter int N      = 64,
    parameter int BYPASS = 1,
    parameter int ZREG   = ZREG_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] ra1,
    input  logic [REG_AW-1:0] ra2,
    input  logic              we3,
    input  logic [REG_AW-1:0] wa3,
    input  logic [N-1:0]      wd3,
    output logic [N-1:0]      rd1,
    output logic [N-1:0]      rd2
);

    localparam logic [REG_AW-1:0] ZADDR = REG_AW'(ZREG);

    logic [N-1:0] regs [NREG];
    logic         byp1;
    logic         byp2;

    // Reset takes priority, so a writeback arriving in a reset cycle is lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (we3 && (wa3 != ZADDR)) begin
            regs[wa3] <= wd3;
        end
    end

    assign byp1 = (BYPASS != 0) && we3 && (wa3 == ra1);
    assign byp2 = (BYPASS != 0) && we3 && (wa3 == ra2);

    assign rd1 = (ra1 == ZADDR) ? '0 : (byp1 ? wd3 : regs[ra1]);
    assign rd2 = (ra2 == ZADDR) ? '0 : (byp2 ? wd3 : regs[ra2]);

endmodule

// File: rtl/signext.sv
// Immediate extender for the LEGv8 D, CB, B and I formats; other opcodes give 0.
module signext #(
    parameter int N = 64
) (
    input  logic [31:0]  a,
    output logic [N-1:0] y
);

    always_comb begin
        y = '0;
        casez (a[31:21])
            11'b111110000?0: y = {{(N-9){a[20]}},  a[20:12]};
            11'b10110100???: y = {{(N-19){a[23]}}, a[23:5]};
            11'b000101?????: y = {{(N-26){a[25]}}, a[25:0]};
            11'b1001000100?: y = {{(N-12){1'b0}},  a[21:10]};
            default:         y = '0;
        endcase
    end

endmodule

// File: rtl/decode_pipe.sv
// LEGv8 decode stage: operand read, immediate extension, load-use hazard
// detection and the ID/EX pipeline register.
module decode_pipe
    import legv8_pkg::*;
#(
    parameter int N      = 64,
    parameter int BYPASS = 1,
    parameter int ZREG   = ZREG_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       instr_D,
    input  logic              valid_D,
    input  logic [N-1:0]      pc_D,
    input  logic              reg2loc_D,
    input  logic              regWrite_D,
    input  logic              memRead_D,
    input  logic              flush_D,
    input  logic              regWrite_W,
    input  logic [REG_AW-1:0] wa3_W,
    input  logic [N-1:0]      writeData3_W,
    output logic              stall_D,
    output logic              valid_E,
    output logic [N-1:0]      pc_E,
    output logic [N-1:0]      readData1_E,
    output logic [N-1:0]      readData2_E,
    output logic [N-1:0]      signImm_E,
    output logic [REG_AW-1:0] ra1_E,
    output logic [REG_AW-1:0] ra2_E,
    output logic [REG_AW-1:0] wa_E,
    output logic              regWrite_E,
    output logic              memRead_E
);

    localparam logic [REG_AW-1:0] ZADDR = REG_AW'(ZREG);

    logic [REG_AW-1:0] ra1;
    logic [REG_AW-1:0] ra2;
    logic [REG_AW-1:0] wa;
    logic [N-1:0]      rd1;
    logic [N-1:0]      rd2;
    logic [N-1:0]      sign_imm;
    logic              hazard;
    logic              bubble;

    assign ra1 = instr_D[RN_LSB +: REG_AW];
    assign wa  = instr_D[RT_LSB +: REG_AW];

    mux2 #(.WIDTH(REG_AW)) ra2_mux (
        .d0 (instr_D[RM_LSB +: REG_AW]),
        .d1 (instr_D[RT_LSB +: REG_AW]),
        .s  (reg2loc_D),
        .y  (ra2)
    );

    regfile_bp #(.N(N), .BYPASS(BYPASS), .ZREG(ZREG)) rf (
        .clk   (clk),
        .reset (reset),
        .ra1   (ra1),
        .ra2   (ra2),
        .we3   (regWrite_W),
        .wa3   (wa3_W),
        .wd3   (writeData3_W),
        .rd1   (rd1),
        .rd2   (rd2)
    );

    signext #(.N(N)) imm_ext (
        .a (instr_D),
        .y (sign_imm)
    );

    // A load in EX whose destination feeds this instruction forces a one-cycle
    // stall; the resulting bubble clears memRead_E, so the stall cannot repeat.
    assign hazard  = valid_E && memRead_E && (wa_E != ZADDR) &&
                     ((wa_E == ra1) || (wa_E == ra2));
    assign stall_D = valid_D && !flush_D && hazard;
    assign bubble  = flush_D || stall_D || !valid_D;

    always_ff @(posedge clk) begin
        if (reset || bubble) begin
            valid_E     <= 1'b0;
            pc_E        <= '0;
            readData1_E <= '0;
            readData2_E <= '0;
            signImm_E   <= '0;
            ra1_E       <= '0;
            ra2_E       <= '0;
            wa_E        <= '0;
            regWrite_E  <= 1'b0;
            memRead_E   <= 1'b0;
        end else begin
            valid_E     <= 1'b1;
            pc_E        <= pc_D;
            readData1_E <= rd1;
            readData2_E <= rd2;
            signImm_E   <= sign_imm;
            ra1_E       <= ra1;
            ra2_E       <= ra2;
            wa_E        <= wa;
            regWrite_E  <= regWrite_D;
            memRead_E   <= memRead_D;
        end
    end

endmodule

// File: tb/tb_decode_pipe.sv
// Randomised and directed bench for decode_pipe; drives a write-first and a
// read-old-value instance in parallel against one architectural model.
module tb_decode_pipe;

    localparam int N = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   instr_D;
    logic          valid_D;
    logic [N-1:0]  pc_D;
    logic          reg2loc_D;
    logic          regWrite_D;
    logic          memRead_D;
    logic          flush_D;
    logic          regWrite_W;
    logic [4:0]    wa3_W;
    logic [N-1:0]  writeData3_W;

    logic          stall1, valid1, regWrite1, memRead1;
    logic [N-1:0]  pc1, rd1_1, rd2_1, imm1;
    logic [4:0]    ra1_1, ra2_1, wa1;
    logic          stall0, valid0, regWrite0, memRead0;
    logic [N-1:0]  pc0, rd1_0, rd2_0, imm0;
    logic [4:0]    ra1_0, ra2_0, wa0;

    logic [N-1:0]  mRegs [32];
    logic          mValid, mRegWrite, mMemRead;
    logic [N-1:0]  mPc, mRd1B, mRd2B, mRd1O, mRd2O, mImm;
    logic [4:0]    mRa1, mRa2, mWa;
    logic          lastStall;
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;

    decode_pipe #(.N(N), .BYPASS(1), .ZREG(31)) dut (
        .clk(clk), .reset(reset), .instr_D(instr_D), .valid_D(valid_D), .pc_D(pc_D),
        .reg2loc_D(reg2loc_D), .regWrite_D(regWrite_D), .memRead_D(memRead_D),
        .flush_D(flush_D), .regWrite_W(regWrite_W), .wa3_W(wa3_W),
        .writeData3_W(writeData3_W), .stall_D(stall1), .valid_E(valid1), .pc_E(pc1),
        .readData1_E(rd1_1), .readData2_E(rd2_1), .signImm_E(imm1), .ra1_E(ra1_1),
        .ra2_E(ra2_1), .wa_E(wa1), .regWrite_E(regWrite1), .memRead_E(memRead1)
    );

    decode_pipe #(.N(N), .BYPASS(0), .ZREG(31)) dut_old (
        .clk(clk), .reset(reset), .instr_D(instr_D), .valid_D(valid_D), .pc_D(pc_D),
        .reg2loc_D(reg2loc_D), .regWrite_D(regWrite_D), .memRead_D(memRead_D),
        .flush_D(flush_D), .regWrite_W(regWrite_W), .wa3_W(wa3_W),
        .writeData3_W(writeData3_W), .stall_D(stall0), .valid_E(valid0), .pc_E(pc0),
        .readData1_E(rd1_0), .readData2_E(rd2_0), .signImm_E(imm0), .ra1_E(ra1_0),
        .ra2_E(ra2_0), .wa_E(wa0), .regWrite_E(regWrite0), .memRead_E(memRead0)
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Architectural meaning of each immediate format, as signed integers.
    function automatic logic [N-1:0] refImm(input logic [31:0] ins);
        longint v;
        if (ins[31:21] == 11'h7C0 || ins[31:21] == 11'h7C2) begin
            v = longint'(ins[20:12]);
            if (v >= 256) v -= 512;
        end else if (ins[31:24] == 8'hB4) begin
            v = longint'(ins[23:5]);
            if (v >= 64'sd262144) v -= 64'sd524288;
        end else if (ins[31:26] == 6'b000101) begin
            v = longint'(ins[25:0]);
            if (v >= 64'sd33554432) v -= 64'sd67108864;
        end else if (ins[31:22] == 10'b1001000100) begin
            v = longint'(ins[21:10]);
        end else begin
            v = 0;
        end
        return N'(v);
    endfunction

    function automatic logic [N-1:0] refRead(input logic [4:0] a, input bit byp);
        if (a == 5'd31) return '0;
        if (byp && regWrite_W && (wa3_W == a)) return writeData3_W;
        return mRegs[a];
    endfunction

    task automatic clearEx();
        mValid = 0; mRegWrite = 0; mMemRead = 0;
        mPc = '0; mRd1B = '0; mRd2B = '0; mRd1O = '0; mRd2O = '0; mImm = '0;
        mRa1 = '0; mRa2 = '0; mWa = '0;
    endtask

    task automatic compareAll();
        checkOutput("valid_E", 64'(valid1), 64'(mValid));
        checkOutput("pc_E", pc1, mPc);
        checkOutput("rd1_bypass", rd1_1, mRd1B);
        checkOutput("rd2_bypass", rd2_1, mRd2B);
        checkOutput("signImm_E", imm1, mImm);
        checkOutput("ra1_E", 64'(ra1_1), 64'(mRa1));
        checkOutput("ra2_E", 64'(ra2_1), 64'(mRa2));
        checkOutput("wa_E", 64'(wa1), 64'(mWa));
        checkOutput("regWrite_E", 64'(regWrite1), 64'(mRegWrite));
        checkOutput("memRead_E", 64'(memRead1), 64'(mMemRead));
        checkOutput("valid_E_old", 64'(valid0), 64'(mValid));
        checkOutput("rd1_old", rd1_0, mRd1O);
        checkOutput("rd2_old", rd2_0, mRd2O);
    endtask

    task automatic applyStimulus(input logic rst, input logic [31:0] ins, input logic v,
                                 input logic [N-1:0] pc, input logic r2l, input logic rw,
                                 input logic mr, input logic fl, input logic we,
                                 input logic [4:0] wa, input logic [N-1:0] wd);
        logic [4:0] a1, a2;
        logic       expStall;
        reset = rst; instr_D = ins; valid_D = v; pc_D = pc; reg2loc_D = r2l;
        regWrite_D = rw; memRead_D = mr; flush_D = fl;
        regWrite_W = we; wa3_W = wa; writeData3_W = wd;
        a1 = ins[9:5];
        a2 = r2l ? ins[4:0] : ins[20:16];
        #2;
        expStall = v && !fl && mValid && mMemRead && (mWa != 5'd31) && ((mWa == a1) || (mWa == a2));
        lastStall = stall1;
        checkOutput("stall_D", 64'(stall1), 64'(expStall));
        checkOutput("stall_D_old", 64'(stall0), 64'(expStall));
        @(posedge clk);
        if (rst) begin
            clearEx();
            for (int i = 0; i < 32; i++) mRegs[i] = '0;
        end else begin
            if (!v || fl || expStall) begin
                clearEx();
            end else begin
                mValid = 1; mPc = pc; mImm = refImm(ins);
                mRd1B = refRead(a1, 1); mRd2B = refRead(a2, 1);
                mRd1O = refRead(a1, 0); mRd2O = refRead(a2, 0);
                mRa1 = a1; mRa2 = a2; mWa = ins[4:0];
                mRegWrite = rw; mMemRead = mr;
            end
            if (we && (wa != 5'd31)) mRegs[wa] = wd;
        end
        #1;
        compareAll();
    endtask

    function automatic logic [31:0] mkAdd(input logic [4:0] rd, input logic [4:0] rn, input logic [4:0] rm);
        return {11'h458, rm, 6'd0, rn, rd};
    endfunction

    function automatic logic [31:0] mkLdur(input logic [4:0] rt, input logic [4:0] rn);
        return {11'h7C2, 9'd8, 2'b00, rn, rt};
    endfunction

    function automatic logic [4:0] pickReg();
        case ($urandom_range(0, 5))
            0: return 5'd1;
            1: return 5'd2;
            2: return 5'd3;
            3: return 5'd31;
            default: return 5'($urandom_range(0, 31));
        endcase
    endfunction

    initial begin
        logic [31:0] ins;
        logic        mr;
        clearEx();
        for (int i = 0; i < 32; i++) mRegs[i] = '0;

        // Reset with a writeback that must be discarded, then read X5.
        applyStimulus(1, 32'd0, 0, '0, 0, 0, 0, 0, 1, 5'd7, 64'hAA);
        checkOutput("reset_valid", 64'(valid1), 64'd0);
        applyStimulus(0, mkAdd(5'd0, 5'd5, 5'd6), 1, 64'h100, 0, 1, 0, 0, 0, 5'd0, '0);
        checkOutput("x5_zero", rd1_1, 64'd0);

        // Same-cycle write of X3 while it is being read.
        applyStimulus(0, 32'd0, 0, '0, 0, 0, 0, 0, 1, 5'd3, 64'h1111);
        applyStimulus(0, mkAdd(5'd9, 5'd3, 5'd3), 1, 64'h104, 0, 1, 0, 0, 1, 5'd3, 64'hDEADBEEF);
        checkOutput("x3_bypass", rd1_1, 64'hDEADBEEF);
        checkOutput("x3_old", rd1_0, 64'h1111);

        // Zero register ignores writes, including same-cycle ones.
        applyStimulus(0, 32'd0, 0, '0, 0, 0, 0, 0, 1, 5'd31, 64'h55);
        applyStimulus(0, mkAdd(5'd9, 5'd31, 5'd31), 1, 64'h108, 0, 1, 0, 0, 1, 5'd31, 64'h55);
        checkOutput("x31_zero", rd1_1, 64'd0);

        // Load-use: one stall, one bubble, then the ADD; X1 is written during the stall.
        applyStimulus(0, mkLdur(5'd2, 5'd1), 1, 64'h200, 0, 1, 1, 0, 0, 5'd0, '0);
        applyStimulus(0, mkAdd(5'd4, 5'd2, 5'd1), 1, 64'h204, 0, 1, 0, 0, 1, 5'd1, 64'h77);
        checkOutput("ldu_stall", 64'(lastStall), 64'd1);
        checkOutput("ldu_bubble", 64'(valid1), 64'd0);
        applyStimulus(0, mkAdd(5'd4, 5'd2, 5'd1), 1, 64'h204, 0, 1, 0, 0, 0, 5'd0, '0);
        checkOutput("ldu_released", 64'(lastStall), 64'd0);
        checkOutput("add_valid", 64'(valid1), 64'd1);
        checkOutput("add_ra1", 64'(ra1_1), 64'd2);
        checkOutput("add_rd2", rd2_1, 64'h77);

        // Flush beats the hazard.
        applyStimulus(0, mkLdur(5'd2, 5'd1), 1, 64'h300, 0, 1, 1, 0, 0, 5'd0, '0);
        applyStimulus(0, mkAdd(5'd4, 5'd2, 5'd1), 1, 64'h304, 0, 1, 0, 1, 0, 5'd0, '0);
        checkOutput("flush_nostall", 64'(lastStall), 64'd0);
        checkOutput("flush_bubble", 64'(valid1), 64'd0);

        // Load to X31 never causes a stall.
        applyStimulus(0, mkLdur(5'd31, 5'd1), 1, 64'h400, 0, 1, 1, 0, 0, 5'd0, '0);
        applyStimulus(0, mkAdd(5'd4, 5'd31, 5'd31), 1, 64'h404, 0, 1, 0, 0, 0, 5'd0, '0);
        checkOutput("zreg_nostall", 64'(lastStall), 64'd0);
        checkOutput("zreg_valid", 64'(valid1), 64'd1);

        // Reset during a stall cancels it.
        applyStimulus(0, mkLdur(5'd2, 5'd1), 1, 64'h500, 0, 1, 1, 0, 0, 5'd0, '0);
        applyStimulus(1, mkAdd(5'd4, 5'd2, 5'd1), 1, 64'h504, 0, 1, 0, 0, 0, 5'd0, '0);
        checkOutput("rst_stall_valid", 64'(valid1), 64'd0);
        applyStimulus(0, mkAdd(5'd4, 5'd2, 5'd1), 1, 64'h504, 0, 1, 0, 0, 0, 5'd0, '0);
        checkOutput("post_rst_nostall", 64'(lastStall), 64'd0);
        checkOutput("post_rst_valid", 64'(valid1), 64'd1);

        for (int n = 0; n < 400; n++) begin
            ins = $urandom;
            ins[9:5] = pickReg();
            ins[20:16] = pickReg();
            ins[4:0] = pickReg();
            case ($urandom_range(0, 5))
                0: ins[31:21] = 11'h7C2;
                1: ins[31:21] = 11'h7C0;
                2: ins[31:24] = 8'hB4;
                3: ins[31:26] = 6'b000101;
                4: ins[31:22] = 10'b1001000100;
                default: ;
            endcase
            mr = (ins[31:21] == 11'h7C2) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
            applyStimulus($urandom_range(0, 59) == 0, ins, $urandom_range(0, 7) != 0,
                          {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          mr, $urandom_range(0, 9) == 0, 1'($urandom_range(0, 1)),
                          pickReg(), {$urandom, $urandom});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
